dm_responder: RTL

Data-memory responder for the pipelined RV32 core: services the core's MEM-stage load/store port (address, write data, write enable, DMType) with byte/halfword/word lane handling. It answers loads combinationally within the same cycle and commits stores on the clock edge. It also decodes a small memory-mapped I/O window: LED register, free-running cycle counter, and sticky misalignment status. It sits outside the core, wired to its data-memory port (core address/write-data/write-enable/DMType outputs in, core load-data input out), with the core's EX/MEM MemRead exported to `mem_r`.

---
 rtl/dm_responder_if.sv | 12 +
 rtl/dm_responder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dm_responder_if.sv
// Core MEM-stage data-memory port: strobes, address, store data, access type and load data.
interface dm_responder_if;
    logic        mem_w;
    logic        mem_r;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dm_type;
    logic [31:0] rdata;

    modport master (output mem_w, mem_r, addr, wdata, dm_type, input rdata);
    modport slave  (input mem_w, mem_r, addr, wdata, dm_type, output rdata);
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: byte/half/word RAM with combinational loads and clocked stores.
// Define DM_MMIO_EN to add the MMIO window (LED, CYCLE counter, W1C STATUS) at addr[31]=1.
module dm_responder #(
    parameter int ADDR_W = 10,
    parameter int LED_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    dm_responder_if.slave    bus,
    output logic             misalign_err,
    output logic [LED_W-1:0] led
);
    localparam logic [31:0] LED_ADDR    = 32'h8000_0000;
    localparam logic [31:0] CYCLE_ADDR  = 32'h8000_0004;
    localparam logic [31:0] STATUS_ADDR = 32'h8000_0008;

    logic [31:0]       mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] widx;
    logic              is_half, is_byte, is_word;
    logic              aligned, is_mmio, misal, ram_we;
    logic [3:0]        be;
    logic [31:0]       wd;
    logic              err_q, err_d;
    logic              unused_bits;

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] t);
        logic [15:0] h;
        logic [7:0]  b;
        h = off[1] ? w[31:16] : w[15:0];
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        case (t)
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b010:  load_ext = {16'h0, h};
            3'b011:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'h0, b};
            default: load_ext = w;
        endcase
    endfunction

    assign widx        = bus.addr[ADDR_W+1:2];
    assign unused_bits = ^bus.addr[31:ADDR_W+2];
    assign is_half     = (bus.dm_type == 3'b001) || (bus.dm_type == 3'b010);
    assign is_byte     = (bus.dm_type == 3'b011) || (bus.dm_type == 3'b100);
    assign is_word     = !is_half && !is_byte;
    assign aligned     = is_word ? (bus.addr[1:0] == 2'b00) : (is_half ? !bus.addr[0] : 1'b1);
`ifdef DM_MMIO_EN
    assign is_mmio     = bus.addr[31];
`else
    assign is_mmio     = 1'b0;
`endif
    // Non-word MMIO accesses are silently ignored and never flag misalignment.
    assign misal  = (bus.mem_r || bus.mem_w) && !aligned && !(is_mmio && !is_word);
    assign ram_we = bus.mem_w && !misal && !is_mmio;

    always_comb begin
        be = 4'b1111;
        wd = bus.wdata;
        if (is_half) begin
            be = bus.addr[1] ? 4'b1100 : 4'b0011;
            wd = {2{bus.wdata[15:0]}};
        end else if (is_byte) begin
            be = 4'b0001 << bus.addr[1:0];
            wd = {4{bus.wdata[7:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[widx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

`ifdef DM_MMIO_EN
    logic             mmio_we;
    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      cyc_q, cyc_d;

    assign mmio_we = bus.mem_w && is_mmio && is_word && aligned;

    always_comb begin
        led_d = led_q;
        cyc_d = cyc_q + 32'd1;
        err_d = err_q;
        if (mmio_we && bus.addr == LED_ADDR)   led_d = bus.wdata[LED_W-1:0];
        if (mmio_we && bus.addr == CYCLE_ADDR) cyc_d = bus.wdata;
        if (mmio_we && bus.addr == STATUS_ADDR && bus.wdata[0]) err_d = 1'b0;
        // A new misalignment overrides a same-cycle clear.
        if (misal) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q <= '0;
            cyc_q <= '0;
            err_q <= 1'b0;
        end else begin
            led_q <= led_d;
            cyc_q <= cyc_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        bus.rdata = 32'h0;
        if (bus.mem_r && !misal) begin
            if (!is_mmio) begin
                bus.rdata = load_ext(mem_q[widx], bus.addr[1:0], bus.dm_type);
            end else if (is_word) begin
                case (bus.addr)
                    LED_ADDR:    bus.rdata = {{(32-LED_W){1'b0}}, led_q};
                    CYCLE_ADDR:  bus.rdata = cyc_q;
                    STATUS_ADDR: bus.rdata = {31'h0, err_q};
                    default:     bus.rdata = 32'h0;
                endcase
            end
        end
    end

    assign led = led_q;
`else
    assign err_d = err_q || misal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    always_comb begin
        bus.rdata = 32'h0;
        if (bus.mem_r && !misal) bus.rdata = load_ext(mem_q[widx], bus.addr[1:0], bus.dm_type);
    end

    assign led = '0;
`endif

    assign misalign_err = err_q;
endmodule
